serial_full_adder_seq: RTL

Bit-serial N-bit adder built around the single full-adder cell (a0, b0, c0 -> s0, c1) used in the combinational adder stage. This block is the sequencer that sits directly upstream of that cell and consumes its output. It accepts two operands and a carry-in, then feeds the cell one bit pair per clock, LSB first, with the carry registered between cycles. It collects the sum bits and presents the result through a valid/ready handshake.

---
 rtl/serial_full_adder_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/serial_full_adder_seq.sv
// ---------------------------------------------------------------------------
// serial_full_adder_seq
//
// Bit-serial WIDTH-bit adder. The block accepts two operands and a carry-in,
// then feeds a single full-adder cell one bit pair per clock, LSB first. The
// carry is registered between steps. The sum bits are collected and the
// result is offered on a valid/ready handshake.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   a, b, cin are valid
//   in_ready   operands can be accepted (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  sum and cout are valid (DONE only)
//   out_ready  consumer accepts the result
//   sum        registered WIDTH-bit sum
//   cout       registered carry-out
//   busy       operation in flight or result pending (SHIFT or DONE)
// ---------------------------------------------------------------------------
module serial_full_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // One extra bit so the counter can never wrap inside an operation.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    count_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  // Full-adder cell in XOR/NAND form:
  //   s0 = p ^ c,  c1 = NAND(NAND(a,b), NAND(p,c))  with p = a ^ b
  logic             fa_p;
  logic             fa_g_n;
  logic             fa_t_n;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] s_next;

  assign fa_p   = a_reg[0] ^ b_reg[0];
  assign fa_g_n = ~(a_reg[0] & b_reg[0]);
  assign fa_t_n = ~(fa_p & carry_reg);
  assign fa_s   = fa_p ^ carry_reg;
  assign fa_c   = ~(fa_g_n & fa_t_n);

  // New sum bit enters at the MSB; after WIDTH steps the LSB-first stream
  // lines up with bit 0.
  assign s_next = {fa_s, s_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      s_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      count_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            carry_reg    <= cin;
            s_reg        <= '0;
            count_reg    <= '0;
            state_reg    <= ST_SHIFT;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end

        ST_SHIFT: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          s_reg     <= s_next;
          carry_reg <= fa_c;
          count_reg <= count_reg + CW'(1);
          if (count_reg == LAST_STEP) begin
            // Result registers are only written here, so a reset during
            // SHIFT can never expose a partial sum.
            sum_reg       <= s_next;
            cout_reg      <= fa_c;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end

        ST_DONE: begin
          // sum/cout are left untouched after the handshake.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule
